// File: rtl/rv_track_pkg.sv
// rv_track_pkg: shared track payload/depth constants and pointer/count types.
package rv_track_pkg;
    localparam int TRACK_DATA_WIDTH = 16;
    localparam int TRACK_FIFO_DEPTH = 2;
    localparam int TRACK_PTR_W = $clog2(TRACK_FIFO_DEPTH);
    typedef logic [TRACK_PTR_W-1:0] ptr_t;
    typedef logic [TRACK_PTR_W:0] cnt_t;
    typedef logic [15:0] stall_cnt_t;
endpackage

// File: rtl/rv_track_fifo.sv
// rv_track_fifo: ready/valid track FIFO with combinational bypass mode.
// Define RV_TRACK_FIFO_OCC_EN to add the occupancy and stall_cnt outputs.
module rv_track_fifo
    import rv_track_pkg::*;
#(
    parameter int DATA_WIDTH = TRACK_DATA_WIDTH,
    parameter int DEPTH = TRACK_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  cfg_fifo_en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in
`ifdef RV_TRACK_FIFO_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy,
    output stall_cnt_t             stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic fifo_ready, fifo_valid, clear, push, pop;
    // ready comes from registered count only, so no ready_in -> ready_out path in FIFO mode
    assign fifo_ready = count != (AW+1)'(DEPTH);
    assign fifo_valid = count != '0;
    assign clear = clk_en & flush;
    assign push = cfg_fifo_en & valid_in & fifo_ready & clk_en & ~flush;
    assign pop = cfg_fifo_en & fifo_valid & ready_in & clk_en & ~flush;
    assign ready_out = cfg_fifo_en ? fifo_ready : ready_in;
    assign valid_out = cfg_fifo_en ? fifo_valid : valid_in;
    assign data_out = cfg_fifo_en ? mem[rd_ptr] : data_in;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
`ifdef RV_TRACK_FIFO_OCC_EN
    assign occupancy = count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (clear) stall_cnt <= '0;
        else if (cfg_fifo_en & fifo_valid & ~ready_in & clk_en & (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rv_track_fifo.sv
// tb_rv_track_fifo: directed self-checking bench for rv_track_fifo.
module tb_rv_track_fifo;
    import rv_track_pkg::*;
    logic clk = 0, rst_n = 0, clk_en = 1, cfg_fifo_en = 1, flush = 0;
    logic valid_in = 0, ready_in = 0, ready_out, valid_out;
    logic [15:0] data_in = '0, data_out;
    int checks = 0, failures = 0;
`ifdef RV_TRACK_FIFO_OCC_EN
    logic [1:0] occupancy;
    stall_cnt_t stall_cnt;
`endif

    rv_track_fifo dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cfg_fifo_en(cfg_fifo_en),
        .flush(flush), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
`ifdef RV_TRACK_FIFO_OCC_EN
        , .occupancy(occupancy), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_ready", ready_out, 1);
        check("rst_data", data_out, 0);
        step(); step();
        rst_n = 1;
        step();
        check("idle_valid", valid_out, 0);
        check("idle_ready", ready_out, 1);
        check("idle_data", data_out, 0);
        // fill with downstream stalled
        valid_in = 1; data_in = 16'h0011;
        step();
        check("fill1_valid", valid_out, 1);
        check("fill1_data", data_out, 16'h0011);
        check("fill1_ready", ready_out, 1);
        data_in = 16'h0022;
        step();
        check("full_ready", ready_out, 0);
        check("full_valid", valid_out, 1);
        check("full_data", data_out, 16'h0011);
        valid_in = 0; ready_in = 1;
        #1;
        check("full_no_comb_ready", ready_out, 0);
        step();
        check("drain1_data", data_out, 16'h0022);
        check("drain1_valid", valid_out, 1);
        check("drain1_ready", ready_out, 1);
        step();
        check("drain2_valid", valid_out, 0);
        // streaming through pointer wrap
        valid_in = 1;
        for (int i = 1; i <= 8; i++) begin
            data_in = 16'(i);
            step();
            check("stream_valid", valid_out, 1);
            check("stream_data", data_out, 32'(i));
            check("stream_ready", ready_out, 1);
        end
        valid_in = 0;
        step();
        check("stream_end_valid", valid_out, 0);
        // flush suppresses the concurrent push
        ready_in = 0; valid_in = 1; data_in = 16'h0033;
        step();
        check("pre_flush_valid", valid_out, 1);
        data_in = 16'h0044; flush = 1;
        step();
        check("flush_valid", valid_out, 0);
        check("flush_ready", ready_out, 1);
        flush = 0; valid_in = 0;
        step();
        check("post_flush_valid", valid_out, 0);
        // clk_en low freezes state
        valid_in = 1; data_in = 16'h0066;
        step();
        check("ce_fill_data", data_out, 16'h0066);
        clk_en = 0; data_in = 16'h0077; ready_in = 1;
        step(); step();
        check("ce_hold_valid", valid_out, 1);
        check("ce_hold_data", data_out, 16'h0066);
        check("ce_hold_ready", ready_out, 1);
        clk_en = 1; valid_in = 0;
        step();
        check("ce_drain_valid", valid_out, 0);
        // bypass with a retained entry
        ready_in = 0; valid_in = 1; data_in = 16'hAAAA;
        step();
        cfg_fifo_en = 0; data_in = 16'hBEEF;
        #1;
        check("byp_data", data_out, 16'hBEEF);
        check("byp_valid", valid_out, 1);
        check("byp_ready_lo", ready_out, 0);
        ready_in = 1;
        #1;
        check("byp_ready_hi", ready_out, 1);
        step(); step();
        ready_in = 0;
        #1;
        check("byp_ready_lo2", ready_out, 0);
        cfg_fifo_en = 1; valid_in = 0;
        #1;
        check("retained_valid", valid_out, 1);
        check("retained_data", data_out, 16'hAAAA);
        ready_in = 1;
        step();
        check("retained_drain", valid_out, 0);
`ifdef RV_TRACK_FIFO_OCC_EN
        ready_in = 0; flush = 1;
        step();
        flush = 0;
        check("occ_start", occupancy, 0);
        check("stall_start", stall_cnt, 0);
        valid_in = 1; data_in = 16'h0101;
        step();
        check("occ1", occupancy, 1);
        check("stall_occ1", stall_cnt, 0);
        step();
        check("occ2", occupancy, 2);
        valid_in = 0;
        repeat (4) step();
        check("stall5", stall_cnt, 5);
        check("occ2_hold", occupancy, 2);
        flush = 1;
        step();
        flush = 0;
        check("occ_flush", occupancy, 0);
        check("stall_flush", stall_cnt, 0);
`endif
        // asynchronous reset mid-transfer
        ready_in = 0; valid_in = 1; data_in = 16'h0055;
        step();
        check("pre_rst_valid", valid_out, 1);
        valid_in = 0;
        #2 rst_n = 0;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_ready", ready_out, 1);
        step();
        rst_n = 1;
        step();
        check("post_rst_valid", valid_out, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
